// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and the instruction word that stops fetching.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO that buffers fetched {instruction, pc} pairs.
// Flush has priority over push and pop; storage resets to zero so an empty head reads as 0.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PW'(1);
            if (pop)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (push && !flush) mem_q[wrPtr_q] <= din;
        end
    end

    assign dout  = mem_q[rdPtr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction memory
// and hands {word, pc} to decode through a small FIFO. Define FETCH_BOUNDS_EN to fault on PC >= MEM_DEPTH.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 128,
    parameter int RESET_PC   = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              halted,
    output logic              fault
);

    localparam int EW = DATA_W + ADDR_W;

`ifdef FETCH_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                fifoPush, fifoPop, fifoFlush;
    logic                fifoFull, fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;
    logic [EW-1:0]       headEntry;
    logic                canPush, outOfRange;

    assign fifoFlush  = redirect_valid && (state_q != S_IDLE);
    assign fifoPop    = ins_ready && !fifoEmpty && !fifoFlush;
    assign canPush    = !fifoFull || fifoPop;
    assign outOfRange = BOUNDS_EN && (pc_q >= ADDR_W'(MEM_DEPTH));

    // Redirect overrides everything outside IDLE; a halt word is consumed only when there is room for it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fifoPush = 1'b0;
        if (fifoFlush) begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (outOfRange) begin
                        state_d = S_FAULT;
                    end else if (canPush) begin
                        if (imem_data == DATA_W'(HALT_WORD)) begin
                            state_d = S_HALT;
                        end else begin
                            fifoPush = 1'b1;
                            pc_d     = pc_q + ADDR_W'(1);
                        end
                    end
                end
                S_HALT:  state_d = S_HALT;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .flush (fifoFlush),
        .din   ({imem_data, pc_q}),
        .dout  (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign imem_addr = pc_q;
    assign ins_valid = (fifoCount != '0);
    assign ins_data  = headEntry[EW-1:ADDR_W];
    assign ins_pc    = headEntry[ADDR_W-1:0];
    assign halted    = (state_q == S_HALT);

`ifdef FETCH_BOUNDS_EN
    assign fault = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a behavioural instruction memory, a scoreboard of
// expected {word, pc} pairs, and assertion-based checks. Bounds-fault case runs when FETCH_BOUNDS_EN is defined.
module tb_fetch_controller;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [256];
    exp_t        expQ [$];
    exp_t        popped;
    int          checks = 0;
    int          errors = 0;

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .halted         (halted),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_data = mem[imem_addr[7:0]];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Any accepted transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ins_valid && ins_ready && !redirect_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL sb_unexpected observed pc=%0h expected no transfer", ins_pc);
            end else begin
                popped = expQ.pop_front();
                checkOutput("sb_data", 64'(ins_data), 64'(popped.data));
                checkOutput("sb_pc", 64'(ins_pc), 64'(popped.pc));
            end
        end
    end

    task automatic expectWord(input logic [31:0] pc);
        expQ.push_back('{data: mem[pc[7:0]], pc: pc});
    endtask

    task automatic applyStimulus(input logic doReset, input logic runIn, input logic readyIn);
        @(posedge clk);
        #1;
        rst_n     = !doReset;
        run       = runIn;
        ins_ready = readyIn;
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        run            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ins_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.delete();
    endtask

    task automatic pulseRedirect(input logic [31:0] pc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        expQ.delete();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic waitHalted(input string tag, input int maxCycles);
        for (int i = 0; i < maxCycles && !halted; i++) @(negedge clk);
        checkOutput(tag, 64'(halted), 64'(1));
        repeat (4) @(negedge clk);
        checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'(0));
        checkOutput({tag, "_valid"}, 64'(ins_valid), 64'(0));
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        for (int i = 0; i < maxCycles && !ins_valid; i++) @(negedge clk);
        checkOutput(tag, 64'(ins_valid), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[3]  = 32'h0;
        mem[13] = 32'h0;
        mem[23] = 32'h0;

        // Reset values
        doReset();
        @(negedge clk);
        checkOutput("rst_valid", 64'(ins_valid), 64'(0));
        checkOutput("rst_halted", 64'(halted), 64'(0));
        checkOutput("rst_fault", 64'(fault), 64'(0));
        checkOutput("rst_data", 64'(ins_data), 64'(0));
        checkOutput("rst_pc", 64'(ins_pc), 64'(0));
        checkOutput("rst_addr", 64'(imem_addr), 64'(0));

        // Straight-line run to the halt word at address 3
        for (int p = 0; p < 3; p++) expectWord(32'(p));
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitValid("t1_first_valid", 10);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t1_pc_seq", 64'(ins_pc), 64'(k));
            @(negedge clk);
        end
        waitHalted("t1_halt", 20);
        checkOutput("t1_pc_hold", 64'(imem_addr), 64'(3));

        // Backpressure: FIFO fills, PC stalls at 2, then drains in order
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("t2_pc_stall", 64'(imem_addr), 64'(2));
        checkOutput("t2_valid", 64'(ins_valid), 64'(1));
        checkOutput("t2_head_pc", 64'(ins_pc), 64'(0));
        for (int p = 0; p < 3; p++) expectWord(32'(p));
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitHalted("t2_halt", 20);

        // Redirect with a full FIFO
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("t3_full_valid", 64'(ins_valid), 64'(1));
        pulseRedirect(32'd10);
        for (int p = 10; p < 13; p++) expectWord(32'(p));
        @(negedge clk);
        checkOutput("t3_flushed", 64'(ins_valid), 64'(0));
        @(negedge clk);
        checkOutput("t3_new_valid", 64'(ins_valid), 64'(1));
        checkOutput("t3_new_pc", 64'(ins_pc), 64'(10));
        checkOutput("t3_new_data", 64'(ins_data), 64'(mem[10]));
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitHalted("t3_halt", 20);

        // Redirect out of HALT
        pulseRedirect(32'd20);
        for (int p = 20; p < 23; p++) expectWord(32'(p));
        @(negedge clk);
        checkOutput("t4_halt_clear", 64'(halted), 64'(0));
        waitHalted("t4_halt", 20);
        checkOutput("t4_pc_hold", 64'(imem_addr), 64'(23));

`ifndef FETCH_BOUNDS_EN
        // PC wrap from all-ones to zero
        pulseRedirect(32'hFFFF_FFFF);
        expectWord(32'hFFFF_FFFF);
        for (int p = 0; p < 3; p++) expectWord(32'(p));
        waitValid("t5_valid", 10);
        checkOutput("t5_pc_top", 64'(ins_pc), 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        checkOutput("t5_pc_wrap", 64'(ins_pc), 64'(0));
        waitHalted("t5_halt", 20);
        checkOutput("t5_fault", 64'(fault), 64'(0));
`else
        // Last implemented word is delivered, then the next fetch faults
        pulseRedirect(32'd127);
        expectWord(32'd127);
        repeat (6) @(negedge clk);
        checkOutput("t6_fault", 64'(fault), 64'(1));
        checkOutput("t6_pc_hold", 64'(imem_addr), 64'(128));
        checkOutput("t6_drained", 64'(expQ.size()), 64'(0));
        checkOutput("t6_halted", 64'(halted), 64'(0));
`endif

        // Reset mid-operation with a full FIFO, then run low keeps it idle
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expQ.delete();
        @(negedge clk);
        checkOutput("mr_valid", 64'(ins_valid), 64'(0));
        checkOutput("mr_halted", 64'(halted), 64'(0));
        checkOutput("mr_fault", 64'(fault), 64'(0));
        checkOutput("mr_data", 64'(ins_data), 64'(0));
        checkOutput("mr_pc", 64'(ins_pc), 64'(0));
        checkOutput("mr_addr", 64'(imem_addr), 64'(0));
        repeat (4) @(negedge clk);
        checkOutput("mr_idle_addr", 64'(imem_addr), 64'(0));
        checkOutput("mr_idle_valid", 64'(ins_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
